// File: rtl/rails_pkg.sv
// Shared definitions for the rails feeder: FSM states, buffer depth,
// nibble width and the value driven onto the checker bus while idle.
package rails_pkg;

    localparam int MAX_N = 10;
    localparam int DW    = 4;
    localparam int IDX_W = $clog2(MAX_N + 1);

    localparam logic [DW-1:0] IDLE_NIBBLE = '0;
    localparam logic [DW-1:0] MAX_N_NIB   = DW'(MAX_N);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        REPORT
    } state_t;

endpackage

// File: rtl/rails_feeder_if.sv
// Host and checker signal bundle for the rails feeder.
// The slave modport is the feeder's view; master is the host/checker side.
interface rails_feeder_if;
    import rails_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] data;
    logic          chk_valid;
    logic          chk_result;
    logic          out_valid;
    logic          out_result;
    logic          out_malformed;
    logic          out_timeout;
    logic          busy;

    modport slave (
        input  in_valid, in_data, chk_valid, chk_result,
        output in_ready, data, out_valid, out_result, out_malformed,
               out_timeout, busy
    );

    modport master (
        output in_valid, in_data, chk_valid, chk_result,
        input  in_ready, data, out_valid, out_result, out_malformed,
               out_timeout, busy
    );

endinterface

// File: rtl/rails_perm_check.sv
// Incremental permutation checker: remembers which values 1..N have been
// seen and flags any element that is zero, above N, or repeated.
// o_bad already includes the element presented this cycle, so the caller
// can decide on the last element without waiting a cycle.
module rails_perm_check
    import rails_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_elemValid,
    input  logic [DW-1:0] i_elem,
    input  logic [DW-1:0] i_n,
    output logic          o_bad
);

    localparam int MASK_W = 1 << DW;

    logic [MASK_W-1:0] r_seen;
    logic              r_bad;
    logic              w_elemBad;

    // Classify the element currently on the input.
    always_comb begin
        w_elemBad = (i_elem == IDLE_NIBBLE) || (i_elem > i_n) || r_seen[i_elem];
    end

    assign o_bad = r_bad | (i_elemValid & w_elemBad);

    // Seen-mask and sticky bad flag, cleared at the start of each pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seen <= '0;
            r_bad  <= 1'b0;
        end else if (i_clear) begin
            r_seen <= '0;
            r_bad  <= 1'b0;
        end else if (i_elemValid) begin
            r_bad <= o_bad;
            if (!w_elemBad) begin
                r_seen[i_elem] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rails_feeder.sv
// Rails feeder: loads a pattern from the host, validates it as a
// permutation of 1..N, replays it to the checker and reports the verdict.
// Optional statistics counters are enabled by defining RAILS_FEEDER_STATS_EN.
module rails_feeder
    import rails_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    rails_feeder_if.slave  bus
`ifdef RAILS_FEEDER_STATS_EN
    ,
    output logic [7:0]     pass_cnt,
    output logic [7:0]     fail_cnt,
    output logic [7:0]     err_cnt
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [IDX_W-1:0]  r_n;
    logic [IDX_W-1:0]  r_idx;
    logic [DW-1:0]     r_buf [MAX_N];
    logic [TW-1:0]     r_timer;
    logic              r_result;
    logic              r_malformed;
    logic              r_timeout;

    logic              w_inReady;
    logic [DW-1:0]     w_data;
    logic              w_outValid;
    logic              w_outResult;
    logic              w_hdrValid;
    logic              w_hdrOk;
    logic              w_lastElem;
    logic              w_timerDone;
    logic              w_bad;

    assign w_hdrValid  = bus.in_valid && (bus.in_data != IDLE_NIBBLE);
    assign w_hdrOk     = bus.in_data <= MAX_N_NIB;
    assign w_lastElem  = (r_idx == r_n - 1'b1);
    assign w_timerDone = (r_timer == TW'(TIMEOUT - 1));

    rails_perm_check u_permCheck (
        .clk         (clk),
        .reset       (reset),
        .i_clear     ((r_state == IDLE) && w_hdrValid),
        .i_elemValid ((r_state == LOAD) && bus.in_valid),
        .i_elem      (bus.in_data),
        .i_n         (DW'(r_n)),
        .o_bad       (w_bad)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_data      = IDLE_NIBBLE;
        w_outValid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = 1'b1;
                if (w_hdrValid) begin
                    w_nextState = w_hdrOk ? LOAD : REPORT;
                end
            end
            LOAD: begin
                w_inReady = 1'b1;
                if (bus.in_valid && w_lastElem) begin
                    w_nextState = w_bad ? REPORT : SEND;
                end
            end
            SEND: begin
                w_data = (r_idx == '0) ? DW'(r_n) : r_buf[r_idx - 1'b1];
                if (r_idx == r_n) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (bus.chk_valid || w_timerDone) begin
                    w_nextState = REPORT;
                end
            end
            REPORT: begin
                w_outValid  = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Pattern buffer, index/timer counters and latched status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n         <= '0;
            r_idx       <= '0;
            r_timer     <= '0;
            r_result    <= 1'b0;
            r_malformed <= 1'b0;
            r_timeout   <= 1'b0;
            for (int i = 0; i < MAX_N; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hdrValid) begin
                        r_result  <= 1'b0;
                        r_timeout <= 1'b0;
                        r_idx     <= '0;
                        r_timer   <= '0;
                        if (w_hdrOk) begin
                            r_n         <= IDX_W'(bus.in_data);
                            r_malformed <= 1'b0;
                        end else begin
                            r_malformed <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        r_buf[r_idx] <= bus.in_data;
                        if (w_lastElem) begin
                            r_idx       <= '0;
                            r_malformed <= w_bad;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (r_idx == r_n) begin
                        r_idx   <= '0;
                        r_timer <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.chk_valid) begin
                        r_result <= bus.chk_result;
                    end else if (w_timerDone) begin
                        r_timeout <= 1'b1;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_outResult       = w_outValid & r_result & ~r_malformed & ~r_timeout;
    assign bus.in_ready      = w_inReady;
    assign bus.data          = w_data;
    assign bus.out_valid     = w_outValid;
    assign bus.out_result    = w_outResult;
    assign bus.out_malformed = w_outValid & r_malformed;
    assign bus.out_timeout   = w_outValid & r_timeout;
    assign bus.busy          = (r_state != IDLE);

`ifdef RAILS_FEEDER_STATS_EN
    // Saturating pass/fail/error tallies, updated on each report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err_cnt  <= '0;
        end else if (r_state == REPORT) begin
            if (w_outResult) begin
                if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
            end else begin
                if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
            end
            if (r_malformed || r_timeout) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rails_feeder.sv
// Self-checking bench for rails_feeder: a table of patterns with expected
// verdicts, plus hand-written sequences for timeout, idle header and reset.
module tb_rails_feeder;
    import rails_pkg::*;

    localparam int TO = 255;

    typedef struct {
        string          name;
        logic [3:0]     header;
        logic [0:9][3:0] elems;
        int             delay;
        logic           chkRes;
        logic           expMal;
        logic           expRes;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [9];

    rails_feeder_if bus ();

`ifdef RAILS_FEEDER_STATS_EN
    logic [7:0] passCnt, failCnt, errCnt;
`endif

    rails_feeder #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef RAILS_FEEDER_STATS_EN
        ,
        .pass_cnt (passCnt),
        .fail_cnt (failCnt),
        .err_cnt  (errCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input string nm, input logic [3:0] hdr,
                                   input logic [39:0] el, input int dly,
                                   input logic cr, input logic em, input logic er);
        vec_t v;
        v.name = nm; v.header = hdr; v.elems = el; v.delay = dly;
        v.chkRes = cr; v.expMal = em; v.expRes = er;
        return v;
    endfunction

    task automatic checkVal(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drives header and elements; returns at the negedge after the last transfer.
    task automatic applyStimulus(input vec_t v);
        int cnt;
        cnt = (v.header == 0 || v.header > MAX_N) ? 0 : int'(v.header);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = v.header;
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            checkVal({v.name, " in_ready during load"}, 8'(bus.in_ready), 8'd1);
            bus.in_data = v.elems[i];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 4'd0;
    endtask

    // Checks replay, answers as the checker, then checks the report.
    task automatic checkOutput(input vec_t v);
        logic [3:0] exp;
        if (!v.expMal) begin
            for (int i = 0; i <= int'(v.header); i++) begin
                exp = (i == 0) ? v.header : v.elems[i-1];
                checkVal($sformatf("%s data[%0d]", v.name, i), 8'(bus.data), 8'(exp));
                checkVal({v.name, " no early out_valid"}, 8'(bus.out_valid), 8'd0);
                @(negedge clk);
            end
            checkVal({v.name, " data idle in wait"}, 8'(bus.data), 8'd0);
            checkVal({v.name, " busy in wait"}, 8'(bus.busy), 8'd1);
            repeat (v.delay) @(negedge clk);
            checkVal({v.name, " no out_valid before verdict"}, 8'(bus.out_valid), 8'd0);
            bus.chk_valid  = 1'b1;
            bus.chk_result = v.chkRes;
            @(negedge clk);
            bus.chk_valid  = 1'b0;
            bus.chk_result = 1'b0;
        end
        checkVal({v.name, " out_valid"}, 8'(bus.out_valid), 8'd1);
        checkVal({v.name, " out_result"}, 8'(bus.out_result), 8'(v.expRes));
        checkVal({v.name, " out_malformed"}, 8'(bus.out_malformed), 8'(v.expMal));
        checkVal({v.name, " out_timeout"}, 8'(bus.out_timeout), 8'd0);
        checkVal({v.name, " data at report"}, 8'(bus.data), 8'd0);
        checkVal({v.name, " in_ready at report"}, 8'(bus.in_ready), 8'd0);
        @(negedge clk);
        checkVal({v.name, " out_valid one cycle"}, 8'(bus.out_valid), 8'd0);
        checkVal({v.name, " status low after"}, 8'(bus.out_malformed), 8'd0);
        checkVal({v.name, " in_ready back"}, 8'(bus.in_ready), 8'd1);
        checkVal({v.name, " idle after"}, 8'(bus.busy), 8'd0);
    endtask

    initial begin
        vec_t v;
        int   sawValid;

        vecs[0] = mkVec("perm5",      4'd5,  40'h1234500000, 0, 1'b1, 1'b0, 1'b1);
        vecs[1] = mkVec("perm3_rej",  4'd3,  40'h3120000000, 2, 1'b0, 1'b0, 1'b0);
        vecs[2] = mkVec("dup",        4'd4,  40'h1223000000, 0, 1'b0, 1'b1, 1'b0);
        vecs[3] = mkVec("hdr12",      4'd12, 40'h0,          0, 1'b0, 1'b1, 1'b0);
        vecs[4] = mkVec("perm10",     4'd10, 40'hA987654321, 1, 1'b1, 1'b0, 1'b1);
        vecs[5] = mkVec("perm1",      4'd1,  40'h1000000000, 0, 1'b1, 1'b0, 1'b1);
        vecs[6] = mkVec("zero_elem",  4'd3,  40'h0120000000, 0, 1'b1, 1'b1, 1'b0);
        vecs[7] = mkVec("over_n",     4'd3,  40'h1420000000, 0, 1'b1, 1'b1, 1'b0);
        vecs[8] = mkVec("hdr15",      4'd15, 40'h0,          0, 1'b0, 1'b1, 1'b0);

        bus.in_valid   = 1'b0;
        bus.in_data    = 4'd0;
        bus.chk_valid  = 1'b0;
        bus.chk_result = 1'b0;

        // Reset values
        #12;
        checkVal("reset in_ready", 8'(bus.in_ready), 8'd1);
        checkVal("reset data", 8'(bus.data), 8'd0);
        checkVal("reset out_valid", 8'(bus.out_valid), 8'd0);
        checkVal("reset out_result", 8'(bus.out_result), 8'd0);
        checkVal("reset out_malformed", 8'(bus.out_malformed), 8'd0);
        checkVal("reset out_timeout", 8'(bus.out_timeout), 8'd0);
        checkVal("reset busy", 8'(bus.busy), 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // Header 0 is the idle value and must be ignored
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd0;
        repeat (2) @(negedge clk);
        checkVal("hdr0 busy", 8'(bus.busy), 8'd0);
        checkVal("hdr0 in_ready", 8'(bus.in_ready), 8'd1);
        bus.in_valid = 1'b0;

        // Table-driven patterns
        for (int k = 0; k < 9; k++) begin
            applyStimulus(vecs[k]);
            checkOutput(vecs[k]);
        end

        // Checker silent: timeout exactly TO cycles after WAIT entry
        v = mkVec("timeout", 4'd2, 40'h2100000000, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(v);
        repeat (3) @(negedge clk);
        checkVal("timeout data in wait", 8'(bus.data), 8'd0);
        sawValid = 0;
        for (int t = 1; t < TO; t++) begin
            @(negedge clk);
            if (bus.out_valid) sawValid++;
        end
        checkVal("timeout no early report", 8'(sawValid), 8'd0);
        @(negedge clk);
        checkVal("timeout out_valid", 8'(bus.out_valid), 8'd1);
        checkVal("timeout out_timeout", 8'(bus.out_timeout), 8'd1);
        checkVal("timeout out_result", 8'(bus.out_result), 8'd0);
        checkVal("timeout out_malformed", 8'(bus.out_malformed), 8'd0);
        @(negedge clk);
        checkVal("timeout back idle", 8'(bus.busy), 8'd0);

        // Reset in the middle of SEND aborts without a report
        applyStimulus(vecs[0]);
        checkVal("midsend first nibble", 8'(bus.data), 8'd5);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checkVal("midsend data", 8'(bus.data), 8'd0);
        checkVal("midsend in_ready", 8'(bus.in_ready), 8'd1);
        checkVal("midsend busy", 8'(bus.busy), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        sawValid = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) sawValid++;
        end
        checkVal("midsend no report", 8'(sawValid), 8'd0);
        applyStimulus(vecs[1]);
        checkOutput(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rails_feeder.md
Name: rails_feeder

Overview:
Upstream stage of the rails stack-permutation checker. Accepts one pattern at a time from a host over a nibble-wide valid/ready port: header N, then N elements. It validates the pattern as a permutation of 1..N and buffers it. It then replays it onto the checker's 4-bit data bus one nibble per cycle and returns the checker's verdict, with malformed/timeout status, to the host.

Parameters:
MAX_N, 10, largest legal pattern length; buffer depth.
DW, 4, nibble width of host and checker data buses.
TIMEOUT, 255, max cycles spent in WAIT before a timeout is declared.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  host nibble valid.
in_ready  out  1  feeder can accept a nibble.
in_data  in  DW  host nibble (header or element).
data  out  DW  nibble stream to checker; 0 when idle.
chk_valid  in  1  checker verdict strobe.
chk_result  in  1  checker verdict (1 = achievable).
out_valid  out  1  one-cycle pattern-complete strobe.
out_result  out  1  checker verdict; 0 if malformed or timeout.
out_malformed  out  1  pattern rejected locally, not sent.
out_timeout  out  1  checker did not answer within TIMEOUT.
busy  out  1  state != IDLE.

Behaviour:
- Reset values: in_ready=1, data=0, out_valid=0, out_result=0, out_malformed=0, out_timeout=0, busy=0. Buffer, seen-mask, counters and state are cleared. Reset mid-operation aborts the pattern; no report is issued.
- Transfer occurs on in_valid && in_ready. in_ready=1 only in IDLE and LOAD.
- IDLE: header==0 is ignored (idle value). 1<=N<=MAX_N latches N, clears the seen-mask, idx=0 and goes to LOAD. N>MAX_N is consumed; next cycle REPORT with malformed=1.
- LOAD: each element is stored at buf[idx] and idx increments. Element of 0, >N, or already set in the seen-mask sets the sticky bad flag; otherwise the mask bit is set. Acceptance continues until N elements are received. Next cycle goes to REPORT if bad, else SEND.
- SEND: data=N in first cycle, then buf[0..N-1] on consecutive cycles; N+1 cycles total, no gaps. Next state is WAIT with data=0.
- WAIT: timer counts from 0. If chk_valid is seen, latch chk_result and go to REPORT. If timer==TIMEOUT-1 without chk_valid, go to REPORT with timeout=1. chk_valid outside WAIT is ignored.
- REPORT: single cycle with out_valid=1 and status outputs valid. Status outputs are 0 whenever out_valid=0. Next state is IDLE.
- Latency: last element accepted → first data nibble is 1 cycle later. chk_valid → out_valid is 1 cycle later.
- Widths: idx/counters are ceil(log2(MAX_N+1)) bits; timer is ceil(log2(TIMEOUT+1)) bits, saturating, never wrapping.

Optional Feature:
- RAILS_FEEDER_STATS_EN defined: adds output ports pass_cnt[7:0], fail_cnt[7:0] and err_cnt[7:0], all reset to 0.
  - pass_cnt and fail_cnt increment on REPORT by out_result.
  - err_cnt increments on malformed or timeout.
  - Counters saturate at 255.
- Macro undefined: these ports and registers do not exist.

Decomposition:
- Package rails_pkg holds the state enum (IDLE, LOAD, SEND, WAIT, REPORT), MAX_N, DW, and the idle nibble constant 0.
- One sub-module, rails_perm_check: incremental range/duplicate checker holding the seen-mask, with clear, element strobe, N in and bad flag out.

Test Plan:
- Host sends 5,1,2,3,4,5 and checker answers valid=1 result=1 → data shows 5,1,2,3,4,5 on 6 consecutive cycles; out_valid=1, out_result=1, other flags 0.
- Host sends 3,3,1,2 and checker returns result=0 → out_result=0, out_malformed=0.
- Host sends 4,1,2,2,3 → no nibbles on data; out_malformed=1, out_result=0.
- Host sends header 12 → consumed immediately, out_malformed=1 next cycle, in_ready back to 1.
- Checker silent after a legal pattern → out_timeout=1 exactly TIMEOUT cycles after WAIT entry.
- Reset asserted mid-SEND → data=0 and in_ready=1 immediately; no out_valid; next pattern proceeds normally.
